// File: rtl/affinex_pkg.sv
// Shared types and default sizing for the affine accumulator slice.
package affinex_pkg;

  localparam int WIDTH_DEF     = 16;
  localparam int FRAC_BITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/affine_acc_if.sv
// Product-in / result-out handshake bundle between the multiplier, accumulator and consumer.
interface affine_acc_if
  import affinex_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic                 clear_i;
  logic [WIDTH-1:0]     offset_i;
  logic [2*WIDTH-1:0]   prod_i;
  logic                 prod_valid_i;
  logic [WIDTH-1:0]     out_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 sat_o;
  logic                 busy_o;
  logic                 drop_o;

  modport master (
    output clear_i, offset_i, prod_i, prod_valid_i, out_ready_i,
    input  out_o, out_valid_o, sat_o, busy_o, drop_o
  );

  modport slave (
    input  clear_i, offset_i, prod_i, prod_valid_i, out_ready_i,
    output out_o, out_valid_o, sat_o, busy_o, drop_o
  );

endinterface

// File: rtl/round_sat.sv
// Combinational round-half-up of a Q(2F) accumulator to Q(F), then clip to the signed WIDTH range.
module round_sat #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 2*WIDTH+2
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [WIDTH-1:0] out_o,
  output logic                    sat_o
);

  // One guard bit so the rounding increment can never wrap the accumulator value.
  localparam int RW = ACC_W + 1;
  localparam logic signed [RW-1:0] HALF_C = {{(RW-1){1'b0}}, 1'b1} <<< (FRAC_BITS - 1);
  localparam logic signed [RW-1:0] MAX_C  = {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] MIN_C  = {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [RW-1:0] sum_s;
  logic signed [RW-1:0] shr_s;

  assign sum_s = $signed({acc_i[ACC_W-1], acc_i}) + HALF_C;
  assign shr_s = sum_s >>> FRAC_BITS;

  // Clip the rounded value and flag whenever clipping happened.
  always_comb begin
    out_o = shr_s[WIDTH-1:0];
    sat_o = 1'b0;
    if (shr_s > MAX_C) begin
      out_o = MAX_C[WIDTH-1:0];
      sat_o = 1'b1;
    end else if (shr_s < MIN_C) begin
      out_o = MIN_C[WIDTH-1:0];
      sat_o = 1'b1;
    end else begin
      out_o = shr_s[WIDTH-1:0];
      sat_o = 1'b0;
    end
  end

endmodule

// File: rtl/affine_acc.sv
// Sums TERMS multiplier products onto a Q-format offset, then rounds, saturates and holds the result.
module affine_acc
  import affinex_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int TERMS     = 2
) (
  input  logic         clk,
  input  logic         rst,
  affine_acc_if.slave  bus
);

  localparam int         ACC_W  = 2*WIDTH + 2;
  localparam logic [2:0] LAST_C = 3'(TERMS - 1);

  state_t                   state_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic        [2:0]        cnt_r;
  logic        [WIDTH-1:0]  out_r;
  logic                     out_valid_r;
  logic                     sat_r;
  logic                     busy_r;
  logic                     drop_r;

  logic signed [ACC_W-1:0]  offset_ext_s;
  logic signed [ACC_W-1:0]  prod_ext_s;
  logic        [WIDTH-1:0]  rs_out_s;
  logic                     rs_sat_s;

  // Offset is Q(F); shift it up to the Q(2F) accumulator scale.
  assign offset_ext_s = {{(ACC_W-WIDTH-FRAC_BITS){bus.offset_i[WIDTH-1]}}, bus.offset_i, {FRAC_BITS{1'b0}}};
  assign prod_ext_s   = {{2{bus.prod_i[2*WIDTH-1]}}, bus.prod_i};

  round_sat #(
    .WIDTH     (WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .ACC_W     (ACC_W)
  ) u_round_sat (
    .acc_i (acc_r),
    .out_o (rs_out_s),
    .sat_o (rs_sat_s)
  );

  // Control FSM with accumulator and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      cnt_r       <= 3'd0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
      sat_r       <= 1'b0;
      busy_r      <= 1'b0;
      drop_r      <= 1'b0;
    end else begin
      drop_r <= 1'b0;
      if (bus.clear_i) begin
        // A product arriving with clear belongs to neither accumulation and is silently dropped.
        state_r     <= ACCUM;
        acc_r       <= offset_ext_s;
        cnt_r       <= 3'd0;
        out_valid_r <= 1'b0;
        busy_r      <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            drop_r <= bus.prod_valid_i;
          end
          ACCUM: begin
            if (bus.prod_valid_i) begin
              acc_r <= acc_r + prod_ext_s;
              cnt_r <= cnt_r + 3'd1;
              if (cnt_r == LAST_C) begin
                state_r <= ROUND;
              end
            end
          end
          ROUND: begin
            drop_r      <= bus.prod_valid_i;
            out_r       <= rs_out_s;
            sat_r       <= rs_sat_s;
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= HOLD;
          end
          HOLD: begin
            drop_r <= bus.prod_valid_i;
            if (bus.out_ready_i) begin
              out_valid_r <= 1'b0;
              state_r     <= IDLE;
            end
          end
          default: begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.out_o       = out_r;
  assign bus.out_valid_o = out_valid_r;
  assign bus.sat_o       = sat_r;
  assign bus.busy_o      = busy_r;
  assign bus.drop_o      = drop_r;

endmodule

// File: tb/tb_affine_acc.sv
// Directed bench for affine_acc (WIDTH=16, FRAC_BITS=8, TERMS=2): vector table plus corner-case sequences.
module tb_affine_acc;

  typedef struct {
    logic [15:0] off;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [15:0] exp_out;
    logic        exp_sat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  affine_acc_if #(.WIDTH(16)) bus ();

  affine_acc #(
    .WIDTH     (16),
    .FRAC_BITS (8),
    .TERMS     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] off);
    bus.clear_i  = 1'b1;
    bus.offset_i = off;
    step();
    bus.clear_i  = 1'b0;
  endtask

  task automatic send(input logic [31:0] p);
    bus.prod_valid_i = 1'b1;
    bus.prod_i       = p;
    step();
    bus.prod_valid_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out"},   {16'h0000, bus.out_o}, 32'h0);
    check({tag, "_valid"}, {31'h0, bus.out_valid_o}, 32'h0);
    check({tag, "_sat"},   {31'h0, bus.sat_o}, 32'h0);
    check({tag, "_busy"},  {31'h0, bus.busy_o}, 32'h0);
    check({tag, "_drop"},  {31'h0, bus.drop_o}, 32'h0);
  endtask

  vec_t tbl [10];
  int   drops;

  initial begin
    tbl[0] = '{16'h0100, 32'h00020000, 32'h00008000, 16'h0380, 1'b0};
    tbl[1] = '{16'h7F00, 32'h7FFF0000, 32'h7FFF0000, 16'h7FFF, 1'b1};
    tbl[2] = '{16'h8000, 32'h80000000, 32'h80000000, 16'h8000, 1'b1};
    tbl[3] = '{16'h0000, 32'h00000080, 32'h00000000, 16'h0001, 1'b0};
    tbl[4] = '{16'h0000, 32'hFFFFFF80, 32'h00000000, 16'h0000, 1'b0};
    tbl[5] = '{16'h0000, 32'hFFFF0000, 32'h00000000, 16'hFF00, 1'b0};
    tbl[6] = '{16'h7F00, 32'h0000FF00, 32'h0000007F, 16'h7FFF, 1'b0};
    tbl[7] = '{16'h7F00, 32'h0000FF00, 32'h00000080, 16'h7FFF, 1'b1};
    tbl[8] = '{16'h8000, 32'h00000000, 32'hFFFFFF80, 16'h8000, 1'b0};
    tbl[9] = '{16'h8000, 32'h00000000, 32'hFFFFFF7F, 16'h8000, 1'b1};

    bus.clear_i      = 1'b0;
    bus.offset_i     = 16'h0000;
    bus.prod_i       = 32'h0;
    bus.prod_valid_i = 1'b0;
    bus.out_ready_i  = 1'b0;
    rst              = 1'b1;
    #1;
    check_all_zero("reset");
    step();
    step();
    rst = 1'b0;
    step();
    check_all_zero("post_reset");

    // Table: clear, two products, one ROUND cycle, then HOLD with the result.
    for (int i = 0; i < 10; i++) begin
      start(tbl[i].off);
      send(tbl[i].p0);
      send(tbl[i].p1);
      check($sformatf("vec%0d_round_valid", i), {31'h0, bus.out_valid_o}, 32'h0);
      check($sformatf("vec%0d_round_busy", i),  {31'h0, bus.busy_o}, 32'h1);
      step();
      check($sformatf("vec%0d_valid", i), {31'h0, bus.out_valid_o}, 32'h1);
      check($sformatf("vec%0d_out", i),   {16'h0, bus.out_o}, {16'h0, tbl[i].exp_out});
      check($sformatf("vec%0d_sat", i),   {31'h0, bus.sat_o}, {31'h0, tbl[i].exp_sat});
      check($sformatf("vec%0d_busy", i),  {31'h0, bus.busy_o}, 32'h0);
      bus.out_ready_i = 1'b1;
      step();
      bus.out_ready_i = 1'b0;
      check($sformatf("vec%0d_accepted", i), {31'h0, bus.out_valid_o}, 32'h0);
    end

    // Back-pressure in HOLD with one stray product.
    start(16'h0100);
    send(32'h00020000);
    send(32'h00008000);
    step();
    drops = 0;
    for (int k = 0; k < 5; k++) begin
      bus.prod_valid_i = (k == 1);
      bus.prod_i       = 32'h12345678;
      step();
      bus.prod_valid_i = 1'b0;
      drops += int'(bus.drop_o);
      check($sformatf("hold%0d_valid", k), {31'h0, bus.out_valid_o}, 32'h1);
      check($sformatf("hold%0d_out", k),   {16'h0, bus.out_o}, 32'h0380);
      check($sformatf("hold%0d_sat", k),   {31'h0, bus.sat_o}, 32'h0);
    end
    check("hold_drop_count", drops, 32'd1);
    bus.out_ready_i = 1'b1;
    step();
    bus.out_ready_i = 1'b0;
    check("hold_release_valid", {31'h0, bus.out_valid_o}, 32'h0);
    check("hold_release_drop",  {31'h0, bus.drop_o}, 32'h0);

    // Ready while idle is ignored; a product in IDLE pulses drop once.
    bus.out_ready_i = 1'b1;
    send(32'h00000100);
    bus.out_ready_i = 1'b0;
    check("idle_drop", {31'h0, bus.drop_o}, 32'h1);
    check("idle_valid", {31'h0, bus.out_valid_o}, 32'h0);
    step();
    check("idle_drop_end", {31'h0, bus.drop_o}, 32'h0);

    // Restart mid-accumulation; the product coincident with clear is discarded.
    start(16'h0000);
    send(32'h00050000);
    bus.clear_i      = 1'b1;
    bus.offset_i     = 16'h0000;
    bus.prod_valid_i = 1'b1;
    bus.prod_i       = 32'h00070000;
    step();
    bus.clear_i      = 1'b0;
    bus.prod_valid_i = 1'b0;
    check("restart_drop", {31'h0, bus.drop_o}, 32'h0);
    check("restart_busy", {31'h0, bus.busy_o}, 32'h1);
    send(32'h00010000);
    send(32'h00010000);
    step();
    check("restart_valid", {31'h0, bus.out_valid_o}, 32'h1);
    check("restart_out",   {16'h0, bus.out_o}, 32'h0200);
    check("restart_sat",   {31'h0, bus.sat_o}, 32'h0);
    bus.out_ready_i = 1'b1;
    step();
    bus.out_ready_i = 1'b0;

    // Asynchronous reset mid-ACCUM: nothing comes out afterwards.
    start(16'h0100);
    send(32'h00020000);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_accum");
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rst_accum_idle%0d_valid", k), {31'h0, bus.out_valid_o}, 32'h0);
      check($sformatf("rst_accum_idle%0d_busy", k),  {31'h0, bus.busy_o}, 32'h0);
    end

    // Asynchronous reset mid-HOLD discards the held result.
    start(16'h0200);
    send(32'h00010000);
    send(32'h00010000);
    step();
    check("pre_rst_hold_valid", {31'h0, bus.out_valid_o}, 32'h1);
    check("pre_rst_hold_out",   {16'h0, bus.out_o}, 32'h0400);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("rst_hold");
    step();
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("rst_hold_idle%0d_valid", k), {31'h0, bus.out_valid_o}, 32'h0);
    end
    bus.out_ready_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
